// File: rtl/tetris_pkg.sv
// Shared Tetris definitions: playfield defaults, piece codes, palette and
// the repaint sequencer state type.
package tetris_pkg;

  localparam int DEFAULT_CELL = 24;
  localparam int DEFAULT_COLS = 10;
  localparam int DEFAULT_ROWS = 20;

  typedef enum logic [2:0] {
    EMPTY = 3'd0,
    I     = 3'd1,
    O     = 3'd2,
    T     = 3'd3,
    S     = 3'd4,
    Z     = 3'd5,
    J     = 3'd6,
    L     = 3'd7
  } piece_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT_RD,
    ST_ISSUE,
    ST_WAIT_DONE,
    ST_ADVANCE,
    ST_FINISH
  } render_state_e;

  // RRR_GGG_BBB colour for each piece code; EMPTY is black so vacated cells erase.
  function automatic logic [8:0] piece_color(input logic [2:0] code);
    logic [8:0] c;
    c = 9'h000;
    case (piece_e'(code))
      EMPTY:   c = 9'h000;
      I:       c = 9'h03F;
      O:       c = 9'h1F8;
      T:       c = 9'h1C7;
      S:       c = 9'h038;
      Z:       c = 9'h1C0;
      J:       c = 9'h007;
      L:       c = 9'h1E0;
      default: c = 9'h000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/Up_count.sv
// Loadable up-counter with enable; load has priority over enable.
module Up_count #(
  parameter int W = 8
) (
  input  logic         CLOCK_50,
  input  logic         resetn,
  input  logic         load,
  input  logic         enable,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn)     q <= '0;
    else if (load)   q <= d;
    else if (enable) q <= q + W'(1);
  end

endmodule

// File: rtl/board_render_seq.sv
// Repaints the playfield: walks the board RAM cell by cell and issues one
// box-renderer request per cell, waiting for its completion each time.
module board_render_seq
  import tetris_pkg::*;
#(
  parameter int COLS     = DEFAULT_COLS,
  parameter int ROWS     = DEFAULT_ROWS,
  parameter int CELL     = DEFAULT_CELL,
  parameter int ORIGIN_X = 200,
  parameter int ORIGIN_Y = 0,
  parameter int AW       = 8
) (
  input  logic          CLOCK_50,
  input  logic          resetn,
  input  logic          go,
  output logic          busy,
  output logic          frame_done,
  output logic [AW-1:0] cell_addr,
  input  logic [2:0]    cell_data,
  output logic          box_start,
  output logic [9:0]    box_x0,
  output logic [8:0]    box_y0,
  output logic [8:0]    box_color,
  input  logic          box_done
);

  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  render_state_e state, state_nx;

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          col_load, col_en, row_load, row_en;
  logic          last_col, last_row;

  assign last_col = (col == CW'(COLS - 1));
  assign last_row = (row == RW'(ROWS - 1));

  Up_count #(.W(CW)) u_col (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .load     (col_load),
    .enable   (col_en),
    .d        ('0),
    .q        (col)
  );

  Up_count #(.W(RW)) u_row (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .load     (row_load),
    .enable   (row_en),
    .d        ('0),
    .q        (row)
  );

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    col_load = 1'b0;
    col_en   = 1'b0;
    row_load = 1'b0;
    row_en   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (go) begin
          state_nx = ST_FETCH;
          col_load = 1'b1;
          row_load = 1'b1;
        end
      end
      ST_FETCH:     state_nx = ST_WAIT_RD;
      ST_WAIT_RD:   state_nx = ST_ISSUE;
      ST_ISSUE:     state_nx = ST_WAIT_DONE;
      ST_WAIT_DONE: if (box_done) state_nx = ST_ADVANCE;
      ST_ADVANCE: begin
        if (!last_col) begin
          col_en   = 1'b1;
          state_nx = ST_FETCH;
        end else if (!last_row) begin
          col_load = 1'b1;
          row_en   = 1'b1;
          state_nx = ST_FETCH;
        end else begin
          state_nx = ST_FINISH;
        end
      end
      ST_FINISH: state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // Strobes are registered from the next state so they line up exactly with
  // the ISSUE/FINISH cycles; colour is captured as WAIT_RD hands over to ISSUE.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      busy       <= 1'b0;
      frame_done <= 1'b0;
      box_start  <= 1'b0;
      cell_addr  <= '0;
      box_x0     <= 10'(ORIGIN_X);
      box_y0     <= 9'(ORIGIN_Y);
      box_color  <= '0;
    end else begin
      busy       <= (state_nx != ST_IDLE);
      box_start  <= (state_nx == ST_ISSUE);
      frame_done <= (state_nx == ST_FINISH);

      if (state == ST_WAIT_RD) box_color <= piece_color(cell_data);

      if (state == ST_IDLE && go) begin
        cell_addr <= '0;
        box_x0    <= 10'(ORIGIN_X);
        box_y0    <= 9'(ORIGIN_Y);
      end

      if (state == ST_ADVANCE) begin
        if (!last_col) begin
          cell_addr <= cell_addr + AW'(1);
          box_x0    <= box_x0 + 10'(CELL);
        end else if (!last_row) begin
          cell_addr <= cell_addr + AW'(1);
          box_x0    <= 10'(ORIGIN_X);
          box_y0    <= box_y0 + 9'(CELL);
        end
      end
    end
  end

endmodule

// File: doc/board_render_seq.md
# board_render_seq

Initiator that repaints the Tetris playfield by scanning the board-state RAM cell by cell. For each cell it issues one draw request to the 24×24 box renderer through that block's `start`/`x0`/`y0`/`color` → `busy`/`done` interface, then waits for `done` before moving on. It sits between the game-logic board RAM and the box renderer, and is triggered once per frame update.

## Interface
Parameters:
- `COLS`, default 10: playfield columns.
- `ROWS`, default 20: playfield rows.
- `CELL`, default 24: cell pitch in pixels; must equal the box renderer size.
- `ORIGIN_X`, default 200: screen X of the top-left pixel of cell (0,0).
- `ORIGIN_Y`, default 0: screen Y of the top-left pixel of cell (0,0).
- `AW`, default 8: board RAM address width; COLS×ROWS ≤ 2^AW.

Ports:
- `CLOCK_50`, in, 1: the only clock.
- `resetn`, in, 1: asynchronous, active-low reset.
- `go`, in, 1: request a full repaint; sampled only in IDLE.
- `busy`, out, 1: high from the cycle after `go` is accepted until FINISH.
- `frame_done`, out, 1: one-cycle pulse when the last cell's `box_done` has been received.
- `cell_addr`, out, AW: board RAM read address, equal to row×COLS+col.
- `cell_data`, in, 3: piece code from the synchronous RAM, valid one cycle after `cell_addr`.
- `box_start`, out, 1: one-cycle draw request to the box renderer.
- `box_x0`, out, 10: cell top-left X.
- `box_y0`, out, 9: cell top-left Y.
- `box_color`, out, 9: RRR_GGG_BBB colour.
- `box_done`, in, 1: renderer completion pulse.

## Operation
- States: IDLE, FETCH, WAIT_RD, ISSUE, WAIT_DONE, ADVANCE, FINISH.
- IDLE → FETCH on `go`. On entry, col, row and the pixel accumulators are cleared to (0, 0, ORIGIN_X, ORIGIN_Y).
- FETCH: drive `cell_addr`. Always go to WAIT_RD.
- WAIT_RD: RAM latency. Always go to ISSUE.
- ISSUE: register `box_color` = palette(`cell_data`), assert `box_start` for exactly one cycle, then go to WAIT_DONE.
- WAIT_DONE: hold `box_x0`, `box_y0` and `box_color` stable. Go to ADVANCE on `box_done`.
- ADVANCE:
  - If col < COLS-1: col+1, x += CELL, go to FETCH.
  - Else if row < ROWS-1: col = 0, x = ORIGIN_X, row+1, y += CELL, go to FETCH.
  - Else go to FINISH.
- FINISH: pulse `frame_done`, then go to IDLE.
- Coordinates come from accumulators only; no multipliers. `cell_addr` is a separate incrementing counter that advances in ADVANCE.
- Palette:
  - 0 → 9'h000 (empty, black)
  - 1 → 9'h03F
  - 2 → 9'h1F8
  - 3 → 9'h1C7
  - 4 → 9'h038
  - 5 → 9'h1C0
  - 6 → 9'h007
  - 7 → 9'h1E0
- Empty cells are drawn black, not skipped, so vacated cells are erased.
- Boundary behaviour:
  - `go` while `busy` is ignored; no restart and no queueing.
  - `box_done` outside WAIT_DONE is ignored.
  - A `box_done` coincident with `box_start` is ignored, because the renderer cannot finish in zero cycles.
  - `resetn` low in any state asynchronously forces IDLE and all outputs to reset values. The renderer is reset by the same `resetn`, so no orphaned request remains.
  - `cell_data` changing during WAIT_DONE has no effect, because colour was latched in ISSUE.

## Timing
- Reset values: `busy`=0, `frame_done`=0, `box_start`=0, `cell_addr`=0, `box_x0`=ORIGIN_X, `box_y0`=ORIGIN_Y, `box_color`=0, state=IDLE.
- `go` accepted at edge N: FETCH at N+1, `box_start` high in cycle N+3.
- Per-cell overhead is 4 cycles (FETCH, WAIT_RD, ISSUE, ADVANCE) plus the renderer latency L, measured from `box_start` to `box_done`.
- Frame time is COLS×ROWS×(L+4)+2 cycles from `go` to `frame_done`.
- `box_start` never reasserts before the `box_done` for the previous request.
- `busy` is registered and is 0 in the `frame_done` cycle's successor.
- Last cell: col=9, row=19, `box_x0`=416, `box_y0`=456. 456+23=479 fits the 9-bit Y range.

## Structure
- Shared package `tetris_pkg`:
  - Piece-code constants (EMPTY, I, O, T, S, Z, J, L).
  - The 8-entry palette as a function `piece_color(code)`.
  - Defaults CELL=24, COLS=10, ROWS=20.
- The col and row counters reuse the existing `Up_count` (load/enable). No other sub-module.
- Target size: 150–250 lines.

## Test plan
- Reset, then `go` with RAM all zero → exactly 200 `box_start` pulses, all with `box_color`=9'h000. The first has (200,0), the last (416,456). `frame_done` fires once.
- RAM[0]=1, RAM[9]=7, RAM[10]=2, RAM[199]=5 → colours 9'h03F at (200,0), 9'h1E0 at (416,0), 9'h1F8 at (200,24), 9'h1C0 at (416,456).
- Renderer model with L=601 and with L=1 → frame times 121002 and 1002 cycles. `box_x0`/`box_y0`/`box_color` are stable throughout each WAIT_DONE.
- `go` pulsed mid-frame plus spurious `box_done` in FETCH → no extra `box_start`, and the sequence is unchanged.
- `resetn` dropped during cell 57's WAIT_DONE → `busy`, `box_start` and `cell_addr` are 0 immediately. After `go` the next request is again cell 0 at (200,0).
